// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Imported by the hazard unit, its counters and the bench.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    IMEM_WAIT
  } hz_state_t;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [31:0] NOP_INSN = 32'h00000013;

endpackage

// File: rtl/pipeline_hazard_unit_sat_counter.sv
// Saturating up-counter with async clear and synchronous clear.
// Stops at MAX instead of wrapping.
module sat_counter #(
  parameter int W = 32,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next count: clear wins, otherwise step until MAX.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != MAX)) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Stall/flush controller for the five-stage pipeline.
// Mealy controls plus pending flush, watchdog and perf counters.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken,
  input  logic                  imem_ready,
  input  logic                  dmem_busy,
  output logic                  pc_write,
  output logic                  if_write,
  output logic                  if_flush,
  output logic                  id_ex_bubble,
  output logic                  pipe_hold,
  output logic                  stall_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int WW = $clog2(TIMEOUT + 1);

  hz_state_t     state_q;
  logic          pend_q;
  logic          tout_q;
  logic [WW-1:0] wait_q;

  logic lu;
  logic r_hold;
  logic r_flush;
  logic r_lu;
  logic r_imem;
  logic r_run;
  logic wait_fire;
  logic wait_clr;

  assign lu = ex_mem_read && (ex_rd != REG_ZERO) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
               (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign r_hold  = dmem_busy;
  assign r_flush = !r_hold && (branch_taken || pend_q);
  assign r_lu    = !r_hold && !r_flush && lu;
  assign r_imem  = !r_hold && !r_flush && !lu && !imem_ready;
  assign r_run   = !r_hold && !r_flush && !lu && imem_ready;

  assign wait_fire = r_hold || r_imem;
  // Counter is already zero whenever the FSM sits in RUN.
  assign wait_clr  = !wait_fire && (state_q != RUN);

  // Priority decode of the pipeline controls; reset forces a bubble.
  always_comb begin
    pc_write     = 1'b0;
    if_write     = 1'b0;
    if_flush     = 1'b1;
    id_ex_bubble = 1'b1;
    pipe_hold    = 1'b0;
    if (rst_n) begin
      if_flush     = 1'b0;
      id_ex_bubble = 1'b0;
      unique case (1'b1)
        r_hold:  pipe_hold = 1'b1;
        r_flush: begin
          pc_write     = 1'b1;
          if_flush     = 1'b1;
          id_ex_bubble = 1'b1;
        end
        r_lu:    id_ex_bubble = 1'b1;
        r_imem:  if_flush = 1'b1;
        r_run: begin
          pc_write = 1'b1;
          if_write = 1'b1;
        end
        default: pipe_hold = 1'b0;
      endcase
    end
  end

  // Wait FSM, pending branch record and sticky watchdog flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      if (r_hold) begin
        state_q <= HOLD;
      end else if (r_imem) begin
        state_q <= IMEM_WAIT;
      end else begin
        state_q <= RUN;
      end
      if (r_hold && branch_taken) begin
        pend_q <= 1'b1;
      end else if (r_flush) begin
        pend_q <= 1'b0;
      end
      if (wait_fire && (wait_q >= WW'(TIMEOUT - 1))) begin
        tout_q <= 1'b1;
      end
    end
  end

  sat_counter #(.W(WW), .MAX(WW'(TIMEOUT))) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wait_clr),
    .inc   (wait_fire),
    .q     (wait_q)
  );

  sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (!pc_write),
    .q     (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (r_flush),
    .q     (flush_count)
  );

  assign stall_timeout = tout_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit.
// Directed hazard cases followed by random traffic and resets.
module tb_pipeline_hazard_unit;
  import hazard_pkg::*;

  localparam int TO = 4;
  localparam int CW = 32;
  localparam longint unsigned CMAX = (64'd1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic id_uses_rs1 = 1'b0;
  logic id_uses_rs2 = 1'b0;
  logic ex_mem_read = 1'b0;
  logic [4:0] ex_rd = '0;
  logic branch_taken = 1'b0;
  logic imem_ready = 1'b1;
  logic dmem_busy = 1'b0;
  logic pc_write, if_write, if_flush, id_ex_bubble, pipe_hold;
  logic stall_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  pipeline_hazard_unit #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .dmem_busy    (dmem_busy),
    .pc_write     (pc_write),
    .if_write     (if_write),
    .if_flush     (if_flush),
    .id_ex_bubble (id_ex_bubble),
    .pipe_hold    (pipe_hold),
    .stall_timeout(stall_timeout),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      ctrl;
    logic            tout;
    longint unsigned stall;
    longint unsigned flush;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  event chk;
  int total = 0;
  int bad = 0;

  bit              m_pend;
  int              m_wait;
  bit              m_tout;
  longint unsigned m_stall;
  longint unsigned m_flush;

  // Monitor: sample 1ns after each issued cycle and score it.
  initial begin
    forever begin
      @chk;
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if ({pc_write, if_write, if_flush, id_ex_bubble, pipe_hold}
            !== e.ctrl) begin
          bad++;
          $display("FAIL ctrl t=%0t got=%b want=%b", $time,
                   {pc_write, if_write, if_flush, id_ex_bubble, pipe_hold},
                   e.ctrl);
        end
        total++;
        if (stall_timeout !== e.tout) begin
          bad++;
          $display("FAIL timeout t=%0t got=%b want=%b", $time,
                   stall_timeout, e.tout);
        end
        total++;
        if (64'(stall_cycles) !== e.stall) begin
          bad++;
          $display("FAIL stall_cycles t=%0t got=%0d want=%0d", $time,
                   stall_cycles, e.stall);
        end
        total++;
        if (64'(flush_count) !== e.flush) begin
          bad++;
          $display("FAIL flush_count t=%0t got=%0d want=%0d", $time,
                   flush_count, e.flush);
        end
      end
    end
  end

  function automatic void model_clear();
    m_pend  = 1'b0;
    m_wait  = 0;
    m_tout  = 1'b0;
    m_stall = 0;
    m_flush = 0;
  endfunction

  // One cycle, called at a falling edge: drive, predict, advance.
  task automatic cyc(input bit ld, input int rd, input int rs1,
                     input int rs2, input bit u1, input bit u2,
                     input bit bt, input bit ir, input bit db);
    bit   hit;
    int   rule;
    exp_t x;
    ex_mem_read  = ld;
    ex_rd        = 5'(rd);
    id_rs1       = 5'(rs1);
    id_rs2       = 5'(rs2);
    id_uses_rs1  = u1;
    id_uses_rs2  = u2;
    branch_taken = bt;
    imem_ready   = ir;
    dmem_busy    = db;
    hit = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (db) rule = 1;
    else if (bt || m_pend) rule = 2;
    else if (hit) rule = 3;
    else if (!ir) rule = 4;
    else rule = 5;
    case (rule)
      1: x.ctrl = 5'b00001;
      2: x.ctrl = 5'b10110;
      3: x.ctrl = 5'b00010;
      4: x.ctrl = 5'b00100;
      default: x.ctrl = 5'b11000;
    endcase
    x.tout  = m_tout;
    x.stall = m_stall;
    x.flush = m_flush;
    sb.push_back(x);
    ->chk;
    if (rule == 1 && bt) m_pend = 1'b1;
    if (rule == 2) begin
      m_pend = 1'b0;
      if (m_flush < CMAX) m_flush++;
    end
    if (x.ctrl[4] == 1'b0 && m_stall < CMAX) m_stall++;
    if (rule == 1 || rule == 4) begin
      if (m_wait < TO) m_wait++;
      if (m_wait == TO) m_tout = 1'b1;
    end else begin
      m_wait = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // Asynchronous reset between clock edges, released at a falling edge.
  task automatic do_reset();
    exp_t x;
    #2;
    rst_n = 1'b0;
    model_clear();
    x.ctrl  = 5'b00110;
    x.tout  = 1'b0;
    x.stall = 0;
    x.flush = 0;
    sb.push_back(x);
    ->chk;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    #2;
    begin
      exp_t x;
      x.ctrl  = 5'b00110;
      x.tout  = 1'b0;
      x.stall = 0;
      x.flush = 0;
      sb.push_back(x);
      ->chk;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    cyc(1, 5, 5, 0, 1, 0, 0, 1, 0);
    idle();
    idle();
    cyc(1, 0, 0, 0, 1, 0, 0, 1, 0);
    cyc(1, 5, 5, 0, 0, 0, 0, 1, 0);
    cyc(1, 7, 0, 7, 0, 1, 0, 1, 0);
    idle();
    cyc(1, 5, 5, 0, 1, 0, 1, 1, 0);
    idle();
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle();
    idle();
    do_reset();
    repeat (6) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) idle();
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    do_reset();
    repeat (3) idle();

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) != 0,
          $urandom_range(0, 4) == 0);
      if (i % 150 == 75) do_reset();
    end

    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Central stall/flush controller for the five-stage RV64 pipeline. Each cycle it decides whether the PC and the IF/ID register advance, hold, or are flushed, and whether a bubble goes into ID/EX. Inputs are load-use operands, branch resolution from EX, and instruction/data memory readiness. It also keeps a pending-flush record across data-memory freezes, a stall watchdog, and two saturating performance counters.

## Interface
- `TIMEOUT`, default 1023: consecutive wait cycles before `stall_timeout` is raised.
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in IF/ID.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: the instruction in IF/ID actually reads that source.
- `ex_mem_read` in 1: the instruction in ID/EX is a load.
- `ex_rd` in 5: destination register of the instruction in ID/EX.
- `branch_taken` in 1: taken branch or jump resolved in EX this cycle.
- `imem_ready` in 1: instruction memory presents a valid word this cycle.
- `dmem_busy` in 1: data memory is not completing; the whole pipeline must freeze.
- `pc_write` out 1: PC register load enable.
- `if_write` out 1: IF/ID load enable.
- `if_flush` out 1: zero the IF/ID instruction; this has priority over `if_write` inside IF/ID.
- `id_ex_bubble` out 1: load a NOP into ID/EX instead of the decoded instruction.
- `pipe_hold` out 1: hold the ID/EX, EX/MEM and MEM/WB registers.
- `stall_timeout` out 1: sticky watchdog error flag.
- `stall_cycles` out CNT_W: count of cycles with `pc_write`=0.
- `flush_count` out CNT_W: count of branch flushes applied.

## Operation
- Control outputs are combinational from the current inputs plus registered state (Mealy). IF/ID and the PC sample them on the same edge.
- Load-use hazard (`lu`): `ex_mem_read` && `ex_rd`!=0 && ((`id_uses_rs1` && `id_rs1`==`ex_rd`) || (`id_uses_rs2` && `id_rs2`==`ex_rd`)).
- Per-cycle priority, highest first:
  1. `dmem_busy`: `pipe_hold`=1, `pc_write`=0, `if_write`=0, `if_flush`=0, `id_ex_bubble`=0. If `branch_taken`=1, set `pending_flush`.
  2. `branch_taken` or `pending_flush`: `pc_write`=1, `if_flush`=1, `id_ex_bubble`=1, `if_write`=0. Clear `pending_flush`. `flush_count`++. `lu` is ignored because the instruction is on the wrong path.
  3. `lu`: `pc_write`=0, `if_write`=0, `id_ex_bubble`=1, `if_flush`=0.
  4. `!imem_ready`: `pc_write`=0, `if_flush`=1 (a bubble enters IF/ID), `id_ex_bubble`=0.
  5. Otherwise: `pc_write`=1, `if_write`=1, all other controls 0.
- FSM states:
  - RUN: no wait in progress.
  - HOLD: entered when `dmem_busy`=1.
  - IMEM_WAIT: entered when a cycle resolves to rule 4.
- Any cycle that resolves to rules 2, 3 or 5 returns the FSM to RUN. Transitions occur at the clock edge based on which rule fired that cycle.
- `wait_cnt`:
  - Increments each cycle in which rule 1 or rule 4 fires.
  - Clears on any other cycle.
  - Saturates at TIMEOUT. Reaching TIMEOUT sets `stall_timeout`.
  - `stall_timeout` clears only on reset.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - State RUN; `pending_flush`, `wait_cnt`, `stall_timeout` and both counters all 0.
  - While in reset, outputs are forced to `pc_write`=0, `if_write`=0, `if_flush`=1, `id_ex_bubble`=1, `pipe_hold`=0.
- Zero-cycle latency from inputs to control outputs.
- Counters, `pending_flush` and `stall_timeout` update on the edge that ends the cycle. They are visible one cycle later.
- A load-use stall lasts exactly one cycle. The next cycle `ex_mem_read` is 0 because ID/EX holds the bubble.
- `branch_taken` during `dmem_busy` is applied on the first cycle in which `dmem_busy`=0. It is never dropped and never applied twice, even if `branch_taken` is also high on that cycle.
- Reset asserted mid-stall discards `pending_flush` and the watchdog count immediately.

## Structure
- `hazard_pkg`:
  - state enum `hz_state_t` {RUN, HOLD, IMEM_WAIT};
  - `REG_ADDR_W`=5 and `REG_ZERO`=5'd0;
  - the NOP encoding constant 32'h00000013, for use by the bench.
- Sub-module `sat_counter` (parameter width, inputs `inc` and `rst_n`, async-clear, saturating). It is instantiated for `stall_cycles`, `flush_count` and `wait_cnt`.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_uses_rs1`=1 -> that cycle `pc_write`=0, `if_write`=0, `id_ex_bubble`=1. Next cycle with `ex_mem_read`=0 -> normal advance, and `stall_cycles`=1.
- Same as the load-use case but `ex_rd`=0, or `id_uses_rs1`=0 -> no stall, `pc_write`=1.
- `branch_taken`=1 together with a load-use match -> `if_flush`=1, `id_ex_bubble`=1, `pc_write`=1, and `flush_count` goes 0 -> 1.
- `dmem_busy`=1 for 3 cycles with `branch_taken`=1 in the first -> `pipe_hold`=1 and `if_flush`=0 for 3 cycles. The 4th cycle has `if_flush`=1. `flush_count`=1, not 2.
- `imem_ready`=0 held with TIMEOUT=4 -> `if_flush`=1 and `pc_write`=0 each cycle. `stall_timeout` rises after the 4th cycle and stays 1 after `imem_ready`=1.
- Async reset pulse during HOLD -> outputs forced to their reset values without waiting for a clock edge. `pending_flush` is lost and no flush occurs after release.
